fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//   Instruction fetch buffer between the PC/instruction-memory fetch stage and decode.
//   Captures {pc, instr} pairs from fetch and holds them in a DEPTH-entry FIFO.
//   Hands them to decode over a valid/ready handshake.
//   Decouples fetch from decode stalls; a single flush discards all wrong-path entries
//   on a branch/jump redirect.
// PARAMETERS
//   DEPTH     4        entries; power of two, >= 2
//   PTR_W     2        log2(DEPTH); pointer width
// PORTS
//   clk        in   1      clock; all state updates on posedge
//   rst        in   1      synchronous, active-high reset
//   flush      in   1      discard every buffered entry (redirect from branch/jump unit)
//   in_valid   in   1      fetch presents a valid {in_pc, in_instr}
//   in_ready   out  1      queue can accept this cycle
//   in_pc      in   32     PC of fetched instruction (0x0000_3000 after PC reset)
//   in_instr   in   32     instruction word read from IM at in_pc
//   out_valid  out  1      head entry valid
//   out_ready  in   1      decode consumes head this cycle
//   out_pc     out  32     PC of head entry
//   out_instr  out  32     instruction of head entry
//   count      out  PTR_W+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//     - wr_ptr = rd_ptr = 0, count = 0.
//     - out_valid = 0, in_ready = 1.
//     - Storage contents are not reset.
//     - rst has priority over flush and over any handshake.
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = (count != DEPTH), combinational from state only.
//     - No push-through when full, even if pop is asserted the same cycle.
//   - out_valid = (count != 0).
//     - out_pc/out_instr = entry[rd_ptr] when valid.
//     - When empty: out_pc = 32'h0, out_instr = NOP (32'h0000_0000).
//   - Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle).
//     - No same-cycle bypass from in_* to out_*.
//   - Normal cycle (no rst/flush):
//     - push writes entry[wr_ptr] and wr_ptr += 1 (mod DEPTH).
//     - pop advances rd_ptr += 1 (mod DEPTH).
//     - count += push - pop; push & pop together leaves count unchanged.
//   - Pointer wrap: PTR_W-bit pointers wrap naturally DEPTH-1 -> 0.
//     - Full vs. empty is distinguished by count only.
//   - Flush (flush=1, rst=0):
//     - Next state: wr_ptr = rd_ptr = 0, count = 0.
//     - Any push or pop in the same cycle is ignored; the word on in_* that cycle is
//       discarded.
//     - out_valid may be 1 during the flush cycle; decode must qualify with flush.
//   - Full + out_ready: pop happens, in_ready rises the next cycle.
//   - Empty + out_ready: no effect.
//   - in_* must stay stable while in_valid & !in_ready (fetch stalls PC).
//     - Not checked here.
// STRUCTURE
//   - Shared package mips_defs:
//     - NOP_INSTR = 32'h0000_0000 (sll $0,$0,0).
//     - PC_RESET = 32'h0000_3000.
//     - Typedef fetch_pkt_t = {pc[31:0], instr[31:0]}.
//   - Sub-module fq_storage: DEPTH x 64-bit register array.
//     - One synchronous write port (we, waddr, wdata).
//     - One asynchronous read port (raddr -> rdata); no reset.
//   - Top level holds pointers, count, handshake and flush control.
// TESTING
//   - Reset: rst=1 for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1,
//     out_instr=0.
//   - Fill: push pc 0x3000,0x3004,0x3008,0x300C with out_ready=0.
//     -> count=4, in_ready=0.
//     -> A 5th in_valid is ignored; out_pc=0x3000.
//   - Drain/wrap: push 6 entries while popping 1 per cycle after the first.
//     -> out_pc sequence 0x3000..0x3014 in order, count steady at 1, pointers wrap.
//   - Full simultaneous: count=4, in_valid=1, out_ready=1.
//     -> pop only, count=3; next cycle push accepted.
//   - Flush: count=3, flush=1 with in_valid=1 (pc 0x3040).
//     -> next cycle count=0, out_valid=0.
//     -> Following push of 0x3080 appears as out_pc=0x3080.
//   - Reset mid-operation: count=2, rst=1 with flush=1 and out_ready=1.
//     -> count=0, out_valid=0; no entry ever emitted afterward.

Source files
------------

// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package   : mips_defs
//  Purpose   : Shared MIPS front-end constants and the fetch packet type.
//  Revision  : 1.0 - initial release
// ============================================================================
package mips_defs;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

endpackage : mips_defs
`default_nettype wire

// File: rtl/fq_storage.sv
`default_nettype none
// ============================================================================
//  Module    : fq_storage
//  Purpose   : DEPTH x WIDTH register array, one synchronous write port and
//              one asynchronous read port. Contents are never reset.
//  Revision  : 1.0 - initial release
// ============================================================================
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry; no reset so the array maps to plain flops/LUTRAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fq_storage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module    : fetch_queue
//  Purpose   : Instruction fetch buffer between fetch and decode. Holds
//              {pc, instr} pairs in a DEPTH-entry FIFO with valid/ready on
//              both sides and a single-cycle flush for branch redirects.
//  Revision  : 1.0 - initial release
// ============================================================================
module fetch_queue
    import mips_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ZERO = '0;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic             push;
    logic             pop;
    fetch_pkt_t       wr_pkt;
    fetch_pkt_t       head_pkt;

    // Handshake qualifiers depend on registered state only, so in_ready has
    // no combinational path from out_ready (no push-through when full).
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != CNT_ZERO);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign wr_pkt.pc    = in_pc;
    assign wr_pkt.instr = in_instr;

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH ($bits(fetch_pkt_t))
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_pkt),
        .raddr (rd_ptr_q),
        .rdata (head_pkt)
    );

    // Head entry is only meaningful while occupied; otherwise present a NOP at PC 0
    assign out_pc    = out_valid ? head_pkt.pc    : 32'h0;
    assign out_instr = out_valid ? head_pkt.instr : NOP_INSTR;
    assign count     = count_q;

    // Next-state for pointers and occupancy; flush zeroes everything and
    // swallows any handshake in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // State register; reset overrides flush and any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : fetch_queue
`default_nettype wire
